// File: rtl/mdp3_pkg.sv
// Shared MDP3 definitions: action codes, entry types, frame layout offsets,
// the serializer FSM encoding and the captured-entry record.
package mdp3_pkg;

   typedef enum logic [7:0] {
      ACT_NEW    = 8'd0,
      ACT_CHANGE = 8'd1,
      ACT_DELETE = 8'd2
   } action_e;

   localparam logic [7:0]  ENTRY_BID   = 8'h30;
   localparam logic [7:0]  ENTRY_OFFER = 8'h31;

   // Frame layout (byte offsets, little-endian multi-byte fields)
   localparam logic [15:0] FRAME_LEN = 16'd24;
   localparam logic [4:0]  SIZE_OFF  = 5'd0;
   localparam logic [4:0]  SEQ_OFF   = 5'd2;
   localparam logic [4:0]  TYPE_OFF  = 5'd6;
   localparam logic [4:0]  ACT_OFF   = 5'd7;
   localparam logic [4:0]  PX_OFF    = 5'd8;
   localparam logic [4:0]  QTY_OFF   = 5'd16;
   localparam logic [4:0]  NORD_OFF  = 5'd20;
   localparam logic [4:0]  LAST_IDX  = 5'd23;

   // Serializer FSM encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SEND = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Entry as captured at the input handshake
   typedef struct packed {
      logic [7:0]  action;
      logic [63:0] price;
      logic [31:0] quantity;
      logic [31:0] num_orders;
      logic [7:0]  entry_type;
   } entry_t;

   // Only New/Change/Delete produce a frame
   function automatic logic action_legal(input logic [7:0] act);
      return (act <= ACT_DELETE);
   endfunction

endpackage

// File: rtl/mdp3_entry_serializer_if.sv
// Entry-in / byte-out stream bundle for the MDP3 entry serializer.
// slave = serializer side, master = the block feeding entries and sinking bytes.
interface mdp3_entry_serializer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_action;
   logic [63:0] in_price;
   logic [31:0] in_quantity;
   logic [31:0] in_num_orders;
   logic [7:0]  in_entry_type;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        out_eop;
   logic        frame_done;
   logic        err_action;

   modport slave (
      input  in_valid, in_action, in_price, in_quantity, in_num_orders, in_entry_type, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop, frame_done, err_action
   );

   modport master (
      output in_valid, in_action, in_price, in_quantity, in_num_orders, in_entry_type, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop, frame_done, err_action
   );
endinterface

// File: rtl/mdp3_entry_serializer.sv
// Serializes one decoded MDP3 book entry per handshake into a 24-byte
// little-endian SBE-style frame on an 8-bit valid/ready stream.
// Every output is a flop; in_valid/out_ready only reach next-state logic.
module mdp3_entry_serializer
   import mdp3_pkg::*;
#(
   parameter logic [31:0] SEQ_INIT = 32'd1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mdp3_entry_serializer_if.slave bus
);

   state_t      state_q,      state_d;
   logic [4:0]  idx_q,        idx_d;
   logic [31:0] seq_q,        seq_d;
   entry_t      hold_q,       hold_d;
   logic        in_ready_q,   in_ready_d;
   logic        out_valid_q,  out_valid_d;
   logic [7:0]  out_data_q,   out_data_d;
   logic        sop_q,        sop_d;
   logic        eop_q,        eop_d;
   logic        frame_done_q, frame_done_d;
   logic        err_q,        err_d;

   // Picks the wire byte at a frame index from the captured entry and seq number
   function automatic logic [7:0] frame_byte(input logic [4:0] idx, input entry_t e,
                                             input logic [31:0] seq);
      logic [63:0] field_v;
      logic [4:0]  rel_v;
      logic [63:0] sh_v;
      field_v = 64'd0;
      rel_v   = 5'd0;
      case (idx) inside
         [SIZE_OFF:SEQ_OFF-5'd1]: begin
            field_v = {48'd0, FRAME_LEN};
            rel_v   = idx - SIZE_OFF;
         end
         [SEQ_OFF:TYPE_OFF-5'd1]: begin
            field_v = {32'd0, seq};
            rel_v   = idx - SEQ_OFF;
         end
         TYPE_OFF: begin
            field_v = {56'd0, e.entry_type};
            rel_v   = 5'd0;
         end
         ACT_OFF: begin
            field_v = {56'd0, e.action};
            rel_v   = 5'd0;
         end
         [PX_OFF:QTY_OFF-5'd1]: begin
            field_v = e.price;
            rel_v   = idx - PX_OFF;
         end
         [QTY_OFF:NORD_OFF-5'd1]: begin
            field_v = {32'd0, e.quantity};
            rel_v   = idx - QTY_OFF;
         end
         [NORD_OFF:LAST_IDX]: begin
            field_v = {32'd0, e.num_orders};
            rel_v   = idx - NORD_OFF;
         end
         default: begin
            field_v = 64'd0;
            rel_v   = 5'd0;
         end
      endcase
      sh_v = field_v >> {rel_v, 3'b000};
      return sh_v[7:0];
   endfunction

   // Next-state logic: accept in IDLE, stream bytes in SEND, one-cycle DONE pulse
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      seq_d        = seq_q;
      hold_d       = hold_q;
      in_ready_d   = in_ready_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      sop_d        = sop_q;
      eop_d        = eop_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               hold_d.action     = bus.in_action;
               hold_d.price      = bus.in_price;
               hold_d.quantity   = bus.in_quantity;
               hold_d.num_orders = bus.in_num_orders;
               hold_d.entry_type = bus.in_entry_type;
               if (action_legal(bus.in_action)) begin
                  state_d     = ST_SEND;
                  idx_d       = 5'd0;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
                  out_data_d  = frame_byte(5'd0, hold_d, seq_q);
                  sop_d       = 1'b1;
                  eop_d       = 1'b0;
               end else begin
                  // Illegal action: flag it, no frame, sequence untouched
                  err_d = 1'b1;
               end
            end else begin
               in_ready_d = 1'b1;
            end
         end
         ST_SEND: begin
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d      = ST_DONE;
                  idx_d        = 5'd0;
                  seq_d        = seq_q + 32'd1;
                  out_valid_d  = 1'b0;
                  out_data_d   = 8'h00;
                  sop_d        = 1'b0;
                  eop_d        = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  idx_d      = idx_q + 5'd1;
                  out_data_d = frame_byte(idx_d, hold_q, seq_q);
                  sop_d      = 1'b0;
                  eop_d      = (idx_d == LAST_IDX);
               end
            end else begin
               // Stalled: byte and flags hold
               out_valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            idx_d       = 5'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= 5'd0;
         seq_q        <= SEQ_INIT;
         hold_q       <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'h00;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         seq_q        <= seq_d;
         hold_q       <= hold_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_sop    = sop_q;
   assign bus.out_eop    = eop_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err_action = err_q;

endmodule

// File: tb/tb_mdp3_entry_serializer.sv
// Directed bench for mdp3_entry_serializer. Two instances run in lockstep on
// the same stimulus: one with the default SEQ_INIT and one starting at
// 0xFFFFFFFF to observe the sequence wrap.
module tb_mdp3_entry_serializer;
   import mdp3_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        out_ready;
   logic [7:0]  in_action;
   logic [63:0] in_price;
   logic [31:0] in_quantity;
   logic [31:0] in_num_orders;
   logic [7:0]  in_entry_type;

   mdp3_entry_serializer_if if_a ();
   mdp3_entry_serializer_if if_b ();

   assign if_a.in_valid      = in_valid;
   assign if_a.in_action     = in_action;
   assign if_a.in_price      = in_price;
   assign if_a.in_quantity   = in_quantity;
   assign if_a.in_num_orders = in_num_orders;
   assign if_a.in_entry_type = in_entry_type;
   assign if_a.out_ready     = out_ready;
   assign if_b.in_valid      = in_valid;
   assign if_b.in_action     = in_action;
   assign if_b.in_price      = in_price;
   assign if_b.in_quantity   = in_quantity;
   assign if_b.in_num_orders = in_num_orders;
   assign if_b.in_entry_type = in_entry_type;
   assign if_b.out_ready     = out_ready;

   mdp3_entry_serializer #(.SEQ_INIT(32'd1)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(if_a));

   mdp3_entry_serializer #(.SEQ_INIT(32'hFFFF_FFFF)) u_wrap (
      .clk(clk), .reset_n(reset_n), .bus(if_b));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]   act;
      logic [63:0]  px;
      logic [31:0]  qty;
      logic [31:0]  nord;
      logic [7:0]   typ;
      logic         exp_err;
      logic [191:0] exp_frame;   // wire order, byte 0 in the top bits
   } vec_t;

   vec_t       vecs [5];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] got_a [24];
   logic [7:0] got_b [24];
   int         n_got;
   int         n_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [191:0] basic_frame(input logic [31:0] s);
      return {8'h18, 8'h00, s[7:0], s[15:8], s[23:16], s[31:24], 8'h30, 8'h00,
              8'h87, 8'hD6, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h0A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
   endfunction

   task automatic send_entry(input logic [7:0] a, input logic [63:0] px, input logic [31:0] q,
                             input logic [31:0] no, input logic [7:0] t);
      int w = 0;
      while (if_a.in_ready !== 1'b1 && w < 60) begin
         tick();
         w++;
      end
      check("in_ready_before_accept", if_a.in_ready, 64'd1);
      in_valid      = 1'b1;
      in_action     = a;
      in_price      = px;
      in_quantity   = q;
      in_num_orders = no;
      in_entry_type = t;
      tick();
      in_valid = 1'b0;
   endtask

   // pattern 0: out_ready held high; pattern 1: out_ready 1,0,0 repeating
   task automatic collect(input int pattern, input int max_bytes, input bit chg_px);
      logic [7:0] held_d;
      logic       held_s;
      logic       held_e;
      bit         stalled = 1'b0;
      int         p = 0;
      held_d = 8'h00;
      held_s = 1'b0;
      held_e = 1'b0;
      n_got  = 0;
      n_cyc  = 0;
      while (n_got < max_bytes && n_cyc < 200) begin
         out_ready = (pattern == 0) ? 1'b1 : ((p % 3) == 0);
         p++;
         if (stalled) begin
            check("stall_hold_data", if_a.out_data, held_d);
            check("stall_hold_sop", if_a.out_sop, held_s);
            check("stall_hold_eop", if_a.out_eop, held_e);
         end
         check("out_valid_mid_frame", if_a.out_valid, 64'd1);
         check("in_ready_busy", if_a.in_ready, 64'd0);
         check($sformatf("sop_at_%0d", n_got), if_a.out_sop, (n_got == 0) ? 64'd1 : 64'd0);
         check($sformatf("eop_at_%0d", n_got), if_a.out_eop, (n_got == 23) ? 64'd1 : 64'd0);
         if (chg_px && n_cyc == 3) in_price = ~in_price;
         stalled = !out_ready;
         held_d  = if_a.out_data;
         held_s  = if_a.out_sop;
         held_e  = if_a.out_eop;
         if (out_ready) begin
            got_a[n_got] = if_a.out_data;
            got_b[n_got] = if_b.out_data;
            n_got++;
         end
         tick();
         n_cyc++;
      end
      check("frame_byte_count", n_got, max_bytes);
      out_ready = 1'b0;
   endtask

   task automatic check_frame(input string name, input logic [191:0] exp);
      for (int k = 0; k < 24; k++)
         check($sformatf("%s_byte%0d", name, k), got_a[k], exp[191-8*k -: 8]);
   endtask

   task automatic check_wrap_seq(input string name, input logic [31:0] s);
      check($sformatf("%s_b2", name), got_b[2], s[7:0]);
      check($sformatf("%s_b3", name), got_b[3], s[15:8]);
      check($sformatf("%s_b4", name), got_b[4], s[23:16]);
      check($sformatf("%s_b5", name), got_b[5], s[31:24]);
   endtask

   task automatic finish_frame();
      check("frame_done_pulse", if_a.frame_done, 64'd1);
      check("done_out_valid", if_a.out_valid, 64'd0);
      check("done_in_ready", if_a.in_ready, 64'd0);
      tick();
      check("frame_done_clear", if_a.frame_done, 64'd0);
      check("in_ready_return", if_a.in_ready, 64'd1);
   endtask

   task automatic illegal_entry(input logic [7:0] a);
      send_entry(a, 64'h1111_2222_3333_4444, 32'd7, 32'd9, ENTRY_OFFER);
      check("err_action_pulse", if_a.err_action, 64'd1);
      check("illegal_out_valid", if_a.out_valid, 64'd0);
      check("illegal_in_ready", if_a.in_ready, 64'd1);
      tick();
      check("err_action_clear", if_a.err_action, 64'd0);
      check("illegal_out_valid_later", if_a.out_valid, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1234_5678, 32'd0, 8'h31, 1'b0,
                  192'h18_00_03_00_00_00_31_01_FF_FF_FF_FF_FF_FF_FF_FF_78_56_34_12_00_00_00_00};
      vecs[1] = '{8'd7, 64'd0, 32'd0, 32'd0, 8'h30, 1'b1, 192'd0};
      vecs[2] = '{8'd2, 64'h0102_0304_0506_0708, 32'hFFFF_FFFF, 32'h0000_0100, 8'h30, 1'b0,
                  192'h18_00_04_00_00_00_30_02_08_07_06_05_04_03_02_01_FF_FF_FF_FF_00_01_00_00};
      vecs[3] = '{8'd3, 64'd5, 32'd5, 32'd5, 8'h31, 1'b1, 192'd0};
      vecs[4] = '{8'd0, 64'h8000_0000_0000_0000, 32'd1, 32'hDEAD_BEEF, 8'h41, 1'b0,
                  192'h18_00_05_00_00_00_41_00_00_00_00_00_00_00_00_80_01_00_00_00_EF_BE_AD_DE};

      reset_n       = 1'b0;
      in_valid      = 1'b0;
      out_ready     = 1'b0;
      in_action     = 8'd0;
      in_price      = 64'd0;
      in_quantity   = 32'd0;
      in_num_orders = 32'd0;
      in_entry_type = 8'd0;
      tick();
      tick();
      check("rst_in_ready", if_a.in_ready, 64'd1);
      check("rst_out_valid", if_a.out_valid, 64'd0);
      check("rst_out_data", if_a.out_data, 64'd0);
      check("rst_sop", if_a.out_sop, 64'd0);
      check("rst_eop", if_a.out_eop, 64'd0);
      check("rst_frame_done", if_a.frame_done, 64'd0);
      check("rst_err_action", if_a.err_action, 64'd0);
      reset_n = 1'b1;
      tick();

      // Basic frame, out_ready high
      send_entry(8'd0, 64'h0000_0000_0012_D687, 32'd10, 32'd3, ENTRY_BID);
      collect(0, 24, 1'b0);
      check("basic_cycles", n_cyc, 64'd24);
      check_frame("basic", basic_frame(32'd1));
      check_wrap_seq("wrap_first", 32'hFFFF_FFFF);
      finish_frame();

      // Same entry under 1,0,0 backpressure
      send_entry(8'd0, 64'h0000_0000_0012_D687, 32'd10, 32'd3, ENTRY_BID);
      collect(1, 24, 1'b0);
      check("bp_cycles", n_cyc, 64'd70);
      check_frame("backpressure", basic_frame(32'd2));
      check_wrap_seq("wrap_second", 32'h0000_0000);
      finish_frame();

      // Table vectors (legal frames continue the sequence, illegal ones do not)
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].exp_err) begin
            illegal_entry(vecs[i].act);
         end else begin
            send_entry(vecs[i].act, vecs[i].px, vecs[i].qty, vecs[i].nord, vecs[i].typ);
            collect(0, 24, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_frame);
            finish_frame();
         end
      end

      // Price changes while the frame is in flight
      send_entry(8'd0, 64'h0000_0000_0012_D687, 32'd10, 32'd3, ENTRY_BID);
      collect(0, 24, 1'b1);
      check_frame("stable", basic_frame(32'd6));
      finish_frame();

      // Reset after byte 10 is accepted
      send_entry(8'd0, 64'h0000_0000_0012_D687, 32'd10, 32'd3, ENTRY_BID);
      collect(0, 11, 1'b0);
      reset_n = 1'b0;
      tick();
      check("midrst_out_valid", if_a.out_valid, 64'd0);
      check("midrst_in_ready", if_a.in_ready, 64'd1);
      check("midrst_out_data", if_a.out_data, 64'd0);
      check("midrst_sop", if_a.out_sop, 64'd0);
      check("midrst_eop", if_a.out_eop, 64'd0);
      reset_n = 1'b1;

      // Illegal action after reset, then a legal frame still carries SEQ_INIT
      illegal_entry(8'd5);
      send_entry(8'd0, 64'h0000_0000_0012_D687, 32'd10, 32'd3, ENTRY_BID);
      collect(0, 24, 1'b0);
      check_frame("after_reset", basic_frame(32'd1));
      check_wrap_seq("wrap_after_reset", 32'hFFFF_FFFF);
      finish_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdp3_entry_serializer.md
# mdp3_entry_serializer

- Transmit-side counterpart of the MDP3 order-book parser.
- Takes one decoded book-update entry (action, price, quantity, order count, entry type) per handshake and emits it as a fixed-length, little-endian, SBE-style byte frame on an 8-bit valid/ready stream.
- Used by the feed generator and loopback benches to drive the parser with exact wire bytes.
- Also intended for an eventual gateway egress path.

## Interface
Parameters:
- SEQ_INIT, 32'd1: sequence number placed in the first frame after reset.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  entry present on in_* fields.
- in_ready  out  1  block can accept an entry.
- in_action  in  8  0=New, 1=Change, 2=Delete; other values illegal.
- in_price  in  64  signed PRICE9 mantissa.
- in_quantity  in  32  unsigned quantity.
- in_num_orders  in  32  unsigned order count.
- in_entry_type  in  8  ASCII '0' (0x30) bid, '1' (0x31) offer; passed through unchecked.
- out_valid  out  1  out_data holds a frame byte.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  frame byte.
- out_sop  out  1  first byte of frame (qualified by out_valid).
- out_eop  out  1  last byte of frame (qualified by out_valid).
- frame_done  out  1  one-cycle pulse in the cycle after the last byte is accepted.
- err_action  out  1  one-cycle pulse when an entry with illegal action is accepted.

## Operation
- Frame layout, 24 bytes, with all multi-byte fields little-endian:
  - bytes 0-1: msg_size = 24
  - bytes 2-5: seq_num
  - byte 6: entry_type
  - byte 7: action
  - bytes 8-15: price
  - bytes 16-19: quantity
  - bytes 20-23: num_orders
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture all fields into a holding register.
  - If action ≤ 2: go to SEND with byte index 0.
  - If action > 2: pulse err_action next cycle, stay in IDLE, emit no frame, leave seq_num unchanged.
- SEND:
  - in_ready=0, out_valid=1.
  - out_data is selected from the holding register and seq_num by byte index 0..23.
  - On out_valid&&out_ready, the index increments.
  - When index=23 is accepted: go to DONE and increment seq_num (modulo 2^32; 0xFFFFFFFF wraps to 0x00000000).
  - out_valid never drops mid-frame. out_data and the flags are stable while out_valid&&!out_ready.
- DONE:
  - One cycle: frame_done=1, out_valid=0, in_ready=0.
  - Then go to IDLE.
- Input fields are sampled only at the accept handshake. Later changes to in_* do not alter a frame in flight.

## Timing
- Reset (reset_n=0 at an edge) sets:
  - state IDLE, index 0, seq_num=SEQ_INIT.
  - in_ready=1, out_valid=0, out_data=0, out_sop=0, out_eop=0, frame_done=0, err_action=0.
- Reset mid-frame aborts the frame immediately. The next frame after reset carries SEQ_INIT.
- Latency: an entry accepted at edge N gives out_valid=1 with byte 0 (out_sop=1) after edge N+1.
- With out_ready held high:
  - byte k is presented in cycle N+1+k.
  - frame_done pulses in cycle N+25.
  - in_ready returns in cycle N+26.
- Peak throughput: one frame per 26 cycles.
- out_sop=1 only at index 0; out_eop=1 only at index 23.
- in_ready and every output are driven from registers, with no combinational path from in_valid or out_ready.
- err_action asserts in the cycle after the illegal accept. in_ready stays 1 throughout.

## Structure
- mdp3_pkg (shared with the parser) holds:
  - action enum (NEW=0, CHANGE=1, DELETE=2).
  - ENTRY_BID=8'h30, ENTRY_OFFER=8'h31.
  - FRAME_LEN=24 and the field byte offsets (SIZE_OFF=0, SEQ_OFF=2, TYPE_OFF=6, ACT_OFF=7, PX_OFF=8, QTY_OFF=16, NORD_OFF=20).
  - The FSM state typedef.
- Single module with no sub-module. The byte select is a case on index using the package offsets.

## Test plan
- **Basic frame:** after reset, accept action=0, price=64'h0000_0000_0012_D687, qty=10, norders=3, type=0x30 with out_ready=1. Required response:
  - byte 0 appears one cycle after accept.
  - bytes: 18 00 01 00 00 00 30 00 87 D6 12 00 00 00 00 00 0A 00 00 00 03 00 00 00.
  - sop on byte 0, eop on byte 23, frame_done in cycle +25.
- **Backpressure:** same entry, out_ready toggling 1,0,0,1,… Required: each byte held stable while stalled, no byte skipped or duplicated, 24 accepted bytes identical to the basic frame.
- **Sequence wrap:** SEQ_INIT=32'hFFFF_FFFF, send two frames. Required: bytes 2-5 are FF FF FF FF, then 00 00 00 00.
- **Illegal action:** accept action=5. Required: err_action pulses one cycle, out_valid stays 0. The next legal frame carries SEQ_INIT.
- **Reset mid-frame:** drop reset_n after byte 10 is accepted. Required: out_valid=0 and in_ready=1 after that edge, then a new entry yields seq=SEQ_INIT.
- **Input stability:** change in_price while in SEND. Required: the frame carries the price sampled at accept, and in_ready stays 0 until after frame_done.
